// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, 2-entry {pc, instr} buffer, redirect flush.
// Optional statistics counters (fetch_count, flush_count) are enabled by defining FETCH_CTRL_STATS_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [1:0]  state_dbg
`ifdef FETCH_CTRL_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        push;
  logic        pop;
  logic [1:0]  count_after;
  logic        can_issue;

  // Handshakes: mem_req is a single-cycle pulse with mem_addr valid in that cycle;
  // mem_rvalid/mem_rdata answer the single outstanding request one or more cycles later;
  // the head entry transfers when instr_valid && instr_ready in the same cycle, unless redirect.
  assign push        = (state == ST_WAIT) && mem_rvalid && !redirect;
  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign count_after = count + {1'b0, push} - {1'b0, pop};

  // A new request is only allowed when its response is guaranteed a free slot.
  assign can_issue = !reset && !redirect && (count_after <= 2'd1) &&
                     ((state == ST_RUN) || ((state == ST_WAIT) && mem_rvalid));

  assign mem_req   = can_issue;
  assign mem_addr  = can_issue ? fetch_pc : 32'h0;
  assign instr     = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign instr_pc  = instr_valid ? fifo_pc[rd_ptr] : 32'h0;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_RUN;
      fetch_pc      <= RESET_PC;
      req_pc        <= 32'h0;
      fifo_pc[0]    <= 32'h0;
      fifo_pc[1]    <= 32'h0;
      fifo_instr[0] <= 32'h0;
      fifo_instr[1] <= 32'h0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
    end else if (redirect) begin
      fetch_pc <= {redirect_target[31:2], 2'b00};
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      // A response still owed by memory must be swallowed before fetching resumes.
      state    <= ((state != ST_RUN) && !mem_rvalid) ? ST_DRAIN : ST_RUN;
    end else begin
      if (can_issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      if (push) begin
        fifo_pc[wr_ptr]    <= req_pc;
        fifo_instr[wr_ptr] <= mem_rdata;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_after;
      case (state)
        ST_RUN: begin
          if (can_issue) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) state <= can_issue ? ST_WAIT : ST_RUN;
        end
        ST_DRAIN: begin
          if (mem_rvalid) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef FETCH_CTRL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'h0;
      flush_count <= 32'h0;
    end else begin
      if (push)     fetch_count <= fetch_count + 32'd1;
      if (redirect) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule
